// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache for the MEM stage.
// Define DCACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module dcache_ctrl #(
    parameter int INDEX_W = 4,
    parameter int OFFS_W  = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFS_W;
    localparam int TAG_W = ADDR_W - INDEX_W - OFFS_W - 2;
    localparam int WA_W  = ADDR_W - 2;
    localparam int DI_W  = INDEX_W + OFFS_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;

    localparam logic [OFFS_W-1:0] CNT_ONE  = 1;
    localparam logic [OFFS_W-1:0] CNT_LAST = '1;

    logic [1:0]        state_q, state_d;
    logic [OFFS_W-1:0] cnt_q, cnt_d;
    logic [WA_W-1:0]   addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [LINES-1:0]  valid_q, valid_d;

    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES*WORDS];

    logic              dwe;
    logic [DI_W-1:0]   dwidx;
    logic [31:0]       dwdata;
    logic              tag_we;

    logic [OFFS_W-1:0]  in_off, q_off;
    logic [INDEX_W-1:0] in_idx, q_idx;
    logic [TAG_W-1:0]   in_tag, q_tag;
    logic               hit_in, hit_q;
    logic               unused_bits;

    assign in_off = Address[OFFS_W+1:2];
    assign in_idx = Address[INDEX_W+OFFS_W+1:OFFS_W+2];
    assign in_tag = Address[ADDR_W-1:INDEX_W+OFFS_W+2];
    assign q_off  = addr_q[OFFS_W-1:0];
    assign q_idx  = addr_q[INDEX_W+OFFS_W-1:OFFS_W];
    assign q_tag  = addr_q[WA_W-1:INDEX_W+OFFS_W];

    assign hit_in = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
    assign hit_q  = valid_q[q_idx] && (tag_q[q_idx] == q_tag);

    assign unused_bits = &{1'b0, Address[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        valid_d   = valid_q;
        dwe       = 1'b0;
        dwidx     = '0;
        dwdata    = '0;
        tag_we    = 1'b0;
        stall     = 1'b0;
        ReadData  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            S_IDLE: begin
                if (MemWrite) begin
                    stall   = 1'b1;
                    addr_d  = Address[ADDR_W-1:2];
                    wdata_d = WriteData;
                    state_d = S_WRITE;
                end else if (MemRead) begin
                    if (hit_in) begin
                        ReadData = data_q[{in_idx, in_off}];
                    end else begin
                        stall   = 1'b1;
                        addr_d  = Address[ADDR_W-1:2];
                        cnt_d   = '0;
                        // Line is invalid until its last word lands.
                        valid_d[in_idx] = 1'b0;
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {q_tag, q_idx, cnt_q, 2'b00};
                if (mem_ack) begin
                    dwe    = 1'b1;
                    dwidx  = {q_idx, cnt_q};
                    dwdata = mem_rdata;
                    cnt_d  = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        valid_d[q_idx] = 1'b1;
                        tag_we  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr_q, 2'b00};
                mem_wdata = wdata_q;
                stall     = ~mem_ack;
                if (mem_ack) begin
                    if (hit_q) begin
                        dwe    = 1'b1;
                        dwidx  = {q_idx, q_off};
                        dwdata = wdata_q;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            stall    = 1'b0;
            ReadData = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (dwe) data_q[dwidx] <= dwdata;
        if (tag_we) tag_q[q_idx] <= q_tag;
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        load_idle;

    always_comb begin
        load_idle  = (state_q == S_IDLE) && !MemWrite && MemRead;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (load_idle && hit_in && hit_cnt_q != 32'hFFFF_FFFF)
            hit_cnt_d = hit_cnt_q + 32'd1;
        if (load_idle && !hit_in && miss_cnt_q != 32'hFFFF_FFFF)
            miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl with a 2-cycle-latency main memory model.
module tb_dcache_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int vectors = 0;
    int errors  = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        txq[$];
    logic [31:0] ldq[$];
    logic [31:0] bmem [logic [31:0]];
    int          wcnt = 0;

    dcache_ctrl dut (
        .clk(clk), .rst(rst),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mval(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return {a[15:0], 16'h5A5A};
    endfunction

    always @(negedge clk) begin
        if (!mem_req) begin
            mem_ack <= 1'b0;
            wcnt    <= 0;
        end else if (wcnt == LAT - 1) begin
            txn_t t;
            mem_ack   <= 1'b1;
            mem_rdata <= mem_we ? 32'h0 : mval(mem_addr);
            wcnt      <= 0;
            vectors++;
            if (txq.size() == 0) begin
                errors++;
                $display("FAIL mem_txn: unexpected we=%0b addr=%h", mem_we, mem_addr);
            end else begin
                t = txq.pop_front();
                if (mem_we !== t.we || mem_addr !== t.addr ||
                    (t.we && mem_wdata !== t.data)) begin
                    errors++;
                    $display("FAIL mem_txn: got we=%0b addr=%h wd=%h, need we=%0b addr=%h wd=%h",
                             mem_we, mem_addr, mem_wdata, t.we, t.addr, t.data);
                end
            end
        end else begin
            mem_ack <= 1'b0;
            wcnt    <= wcnt + 1;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic do_load(input logic [31:0] a, input bit miss, input string nm);
        int  stalls;
        bit  done;
        logic [31:0] wa;
        logic [31:0] exp;
        logic [31:0] got;
        wa = {a[31:2], 2'b00};
        ldq.push_back(mval(wa));
        if (miss)
            for (int i = 0; i < 4; i++) begin
                logic [1:0] w;
                w = i[1:0];
                txq.push_back('{1'b0, {a[31:4], w, 2'b00}, 32'h0});
            end
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        Address  = a;
        stalls   = 0;
        done     = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall) begin
                stalls++;
                step();
            end else begin
                done = 1'b1;
                got  = ReadData;
                exp  = ldq.pop_front();
                vectors++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL %s data: got %h need %h", nm, got, exp);
                end
                if (!miss) begin
                    vectors++;
                    if (mem_req !== 1'b0) begin
                        errors++;
                        $display("FAIL %s hit_req: got %b need 0", nm, mem_req);
                    end
                end
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: stall still high after %0d cycles", nm, stalls);
            ldq.delete();
        end
        vectors++;
        if (stalls != (miss ? 1 + 4 * LAT : 0)) begin
            errors++;
            $display("FAIL %s stalls: got %0d need %0d", nm, stalls, miss ? 1 + 4 * LAT : 0);
        end
        vectors++;
        if (txq.size() != 0) begin
            errors++;
            $display("FAIL %s txns: %0d expected transfers missing", nm, txq.size());
        end
        txq.delete();
        MemRead = 1'b0;
        step();
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input bit both, input string nm);
        int stalls;
        bit done;
        txq.push_back('{1'b1, {a[31:2], 2'b00}, d});
        MemWrite  = 1'b1;
        MemRead   = both;
        Address   = a;
        WriteData = d;
        stalls    = 0;
        done      = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall) begin
                stalls++;
                step();
            end else begin
                done = 1'b1;
            end
        end
        vectors++;
        if (!done || stalls != 1 + (LAT - 1)) begin
            errors++;
            $display("FAIL %s stalls: got %0d need %0d", nm, stalls, LAT);
        end
        vectors++;
        if (txq.size() != 0) begin
            errors++;
            $display("FAIL %s txns: write transfer missing", nm);
        end
        txq.delete();
        bmem[{a[31:2], 2'b00}] = d;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        step();
    endtask

    task automatic test_reset();
        MemRead = 1'b1;
        Address = 32'h40;
        #1;
        vectors++;
        if ({mem_req, mem_we, stall} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: got req/we/stall=%b need 000", {mem_req, mem_we, stall});
        end
        vectors++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || ReadData !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wd=%h rd=%h need 0",
                     mem_addr, mem_wdata, ReadData);
        end
        MemRead = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_refill();
        do_load(32'h40, 1'b1, "refill_40");
    endtask

    task automatic test_hit();
        do_load(32'h48, 1'b0, "hit_48");
        do_load(32'h4C, 1'b0, "hit_4c");
    endtask

    task automatic test_store_hit();
        do_store(32'h44, 32'hDEADBEEF, 1'b0, "st_hit_44");
        do_load(32'h44, 1'b0, "ld_after_st_44");
        do_load(32'h40, 1'b0, "ld_neighbour_40");
    endtask

    task automatic test_store_miss();
        do_store(32'h1000, 32'h12345678, 1'b0, "st_miss_1000");
        do_load(32'h1000, 1'b1, "ld_noalloc_1000");
        do_load(32'h1004, 1'b0, "ld_hit_1004");
    endtask

    task automatic test_priority();
        do_store(32'h48, 32'hCAFEF00D, 1'b1, "st_both_48");
        do_load(32'h48, 1'b0, "ld_after_both_48");
    endtask

    task automatic test_conflict();
        do_load(32'h240, 1'b1, "evict_240");
        do_load(32'h40, 1'b1, "conf_40a");
        do_load(32'h140, 1'b1, "conf_140");
        do_load(32'h40, 1'b1, "conf_40b");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'h40 + 32'(i * 4);
            do_load(a, 1'b0, "b2b_hit");
        end
    endtask

    task automatic test_rst_mid();
        int c;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] w;
            w = i[1:0];
            txq.push_back('{1'b0, {28'h014, w, 2'b00}, 32'h0});
        end
        MemRead = 1'b1;
        Address = 32'h140;
        c = 0;
        while (txq.size() > 3 && c < 40) begin
            step();
            c++;
        end
        vectors++;
        if (txq.size() != 3) begin
            errors++;
            $display("FAIL rst_mid first_word: %0d transfers pending, need 3", txq.size());
        end
        step();
        rst = 1'b1;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid drop: got req=%b stall=%b need 0 0", mem_req, stall);
        end
        txq.delete();
        MemRead = 1'b0;
        step();
        rst = 1'b0;
        step();
        do_load(32'h140, 1'b1, "rst_remiss_140");
        do_load(32'h40, 1'b1, "rst_remiss_40");
    endtask

    initial begin
        bmem[32'h40] = 32'hA0;
        bmem[32'h44] = 32'hA1;
        bmem[32'h48] = 32'hA2;
        bmem[32'h4C] = 32'hA3;
        #2;
        test_reset();
        test_refill();
        test_hit();
        test_store_hit();
        test_store_miss();
        test_priority();
        test_conflict();
        test_back_to_back();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the EX/MEM pipeline register and a slower main memory. It replaces the single-cycle data memory in the MEM stage.
- Hits return data in the same cycle.
- Misses and all stores assert `stall`, which freezes PC, IF/ID, ID/EX and EX/MEM while the cache runs a req/ack transaction on the main-memory port.

Parameters:
- `INDEX_W`, 4: index bits; the cache holds 2^INDEX_W lines (16).
- `OFFS_W`, 2: word-offset bits; each line holds 2^OFFS_W 32-bit words (4).
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `MemRead`  in  1  load request from the MEM stage.
- `MemWrite`  in  1  store request from the MEM stage.
- `Address`  in  ADDR_W  byte address (ALU result); bits [1:0] are ignored.
- `WriteData`  in  32  store data.
- `ReadData`  out  32  load data, valid when `MemRead` is high and `stall` is low.
- `stall`  out  1  combinational freeze request to the hazard logic.
- `mem_req`  out  1  main-memory request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr`  out  ADDR_W  word-aligned main-memory address.
- `mem_wdata`  out  32  main-memory write data.
- `mem_rdata`  in  32  main-memory read data, valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle transfer acknowledge, sampled at the rising edge.

Behaviour:
- Address split:
  - offset = `Address[OFFS_W+1:2]`
  - index = `Address[INDEX_W+OFFS_W+1:OFFS_W+2]`
  - tag = remaining upper bits.
- Storage: per line, one valid bit, one tag and 2^OFFS_W data words. hit = valid[index] & (tag match).
- Reset (async, any state):
  - All valid bits clear; FSM goes to IDLE.
  - `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata` = 0.
  - `ReadData` = 0, `stall` = 0.
  - An in-flight refill or write is abandoned with no partial line marked valid.
- FSM states are IDLE, REFILL and WRITE.
- IDLE:
  - `MemWrite` has priority if both requests are high. Store: `stall` = 1; next state WRITE; latch `Address` and `WriteData`.
  - Load hit: `ReadData` = line word combinationally, `stall` = 0, zero added latency.
  - Load miss: `stall` = 1; next state REFILL; word counter = 0.
  - No request: `stall` = 0, `ReadData` = 0.
- REFILL:
  - `stall` = 1 in every REFILL cycle.
  - `mem_req` = 1, `mem_we` = 0, `mem_addr` = {tag, index, counter, 2'b00}; words are fetched 0..3 in order.
  - On each `mem_ack`: write `mem_rdata` into word[counter], then counter++.
  - On the ack of the last word: set valid and tag for the line, then go to IDLE. The next cycle is a hit, so a miss costs 1 + 4 × (memory latency) cycles.
- WRITE:
  - `mem_req` = 1, `mem_we` = 1, with `mem_addr` and `mem_wdata` taken from the latched values.
  - `stall` = ~`mem_ack`, so the pipeline advances on the ack edge.
  - On ack: if the latched address hits, update that cached word (write-through). A miss does not allocate. Go to IDLE.
- Handshake rules:
  - `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` are held stable from assertion until the ack edge.
  - `mem_req` drops in the cycle after the final ack.
  - `mem_ack` while `mem_req` is low is ignored.
- The counter wraps 3→0, but is only used inside REFILL.
- Inputs are held stable by the stalled pipeline. The cache does not re-sample them during REFILL or WRITE.

Optional Feature:
- Macro `DCACHE_STATS_EN`.
- When defined:
  - Add outputs `hit_count[31:0]` and `miss_count[31:0]`, both reset to 0.
  - `hit_count` increments once per IDLE load hit with `stall` = 0.
  - `miss_count` increments once per IDLE→REFILL transition.
  - Both counters saturate at 0xFFFFFFFF.
- When not defined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then load 0x40, with memory returning 0xA0..0xA3 (2-cycle ack latency each):
  - `stall` is high for 9 cycles.
  - `mem_addr` sequence is 0x40, 0x44, 0x48, 0x4C.
  - The next cycle `ReadData` = 0xA0 with `stall` = 0.
- Load 0x48 after the refill: hit, `ReadData` = 0xA2, `mem_req` stays 0.
- Store 0x44 = 0xDEADBEEF (hit): one `mem_req` with `mem_we` = 1 and `mem_addr` 0x44. Then load 0x44 hits and returns 0xDEADBEEF.
- Store 0x1000 (miss): memory write occurs. Then load 0x1000 misses and refills, confirming no allocate on a write miss.
- Conflict: load 0x40, then load 0x140 (same index, different tag), then load 0x40: all three miss and the line is re-fetched.
- Assert `rst` during the 2nd refill word: `mem_req` drops immediately. A following load to the same address misses again.
